// File: rtl/mux_4x1.sv
// mux_4x1 -- single-bit 4-to-1 selector with a registered observation stage.
//
// Purpose:
//   F follows the selected input i[s] combinationally (no clock needed).
//   A clocked side stage provides a registered copy of F, a one-cycle
//   strobe whenever the sampled select changes, and a saturating counter
//   of registered toggles of F_q for downstream monitoring.
//
// Ports:
//   clk      in   1      rising-edge clock for all registered outputs
//   rst      in   1      synchronous, active-high reset of the registered stage
//   i        in   4      data candidates i[0]..i[3]
//   s        in   2      select, s[1] is MSB
//   F        out  1      combinational F = i[s]
//   F_q      out  1      F registered on clk
//   sel_chg  out  1      one-cycle pulse when sampled s differs from previous
//   tog_cnt  out  CNT_W  saturating count of F_q toggles (cleared only by rst)
//
// Parameters:
//   CNT_W    width of tog_cnt, legal range 2..16 (default 8)

module mux_4x1 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i,
    input  logic [1:0]       s,
    output logic             F,
    output logic             F_q,
    output logic             sel_chg,
    output logic [CNT_W-1:0] tog_cnt
);

    logic             f_d;
    logic             f_q;
    logic [1:0]       s_d;
    logic [1:0]       s_q;
    logic             sel_chg_d;
    logic             sel_chg_q;
    logic [CNT_W-1:0] tog_cnt_d;
    logic [CNT_W-1:0] tog_cnt_q;

    // Purely combinational data path; an X/Z select propagates as X.
    assign F = i[s];

    always_comb begin
        f_d       = F;
        s_d       = s;
        sel_chg_d = (s != s_q);
        tog_cnt_d = tog_cnt_q;
        // A toggle is F differing from the value about to be replaced in f_q;
        // the counter sticks at all-ones instead of wrapping.
        if ((F != f_q) && (tog_cnt_q != '1)) begin
            tog_cnt_d = tog_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q       <= 1'b0;
            s_q       <= '0;
            sel_chg_q <= 1'b0;
            tog_cnt_q <= '0;
        end else begin
            f_q       <= f_d;
            s_q       <= s_d;
            sel_chg_q <= sel_chg_d;
            tog_cnt_q <= tog_cnt_d;
        end
    end

    assign F_q     = f_q;
    assign sel_chg = sel_chg_q;
    assign tog_cnt = tog_cnt_q;

endmodule

// File: tb/tb_mux_4x1.sv
// tb_mux_4x1 -- self-checking bench for mux_4x1 (instantiated with CNT_W=2
// so that counter saturation is reachable in a few cycles).

module tb_mux_4x1;

    localparam int unsigned W    = 2;
    localparam int          MAXC = (1 << W) - 1;

    logic         clk;
    logic         clk_en;
    logic         rst;
    logic [3:0]   i;
    logic [1:0]   s;
    logic         F;
    logic         F_q;
    logic         sel_chg;
    logic [W-1:0] tog_cnt;

    int n_pass;
    int n_chk;

    // Reference state of the registered stage
    int m_fq;
    int m_sp;
    int m_sel;
    int m_cnt;

    mux_4x1 #(.CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .s       (s),
        .F       (F),
        .F_q     (F_q),
        .sel_chg (sel_chg),
        .tog_cnt (tog_cnt)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    endtask

    function automatic int ref_f(input logic [3:0] iv, input logic [1:0] sv);
        return (int'(iv) >> int'(sv)) & 1;
    endfunction

    // One rising edge: advance the model from the sampled inputs, then
    // compare registered outputs shortly after the edge.
    task automatic step();
        int f;
        @(posedge clk);
        f = ref_f(i, s);
        if (rst) begin
            m_fq = 0; m_sp = 0; m_sel = 0; m_cnt = 0;
        end else begin
            m_sel = (int'(s) != m_sp) ? 1 : 0;
            if (f != m_fq) m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
            m_fq = f;
            m_sp = int'(s);
        end
        #1;
        check("F_q", 32'(F_q), 32'(m_fq));
        check("sel_chg", 32'(sel_chg), 32'(m_sel));
        check("tog_cnt", 32'(tog_cnt), 32'(m_cnt));
    endtask

    logic [3:0] comb_i   [9] = '{4'b0000, 4'b0001, 4'b1110, 4'b0010, 4'b1101,
                                 4'b0100, 4'b1011, 4'b1000, 4'b0111};
    logic       comb_f   [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         sat_cnt  [6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        n_pass = 0; n_chk = 0;
        m_fq = 0; m_sp = 0; m_sel = 0; m_cnt = 0;
        clk_en = 1'b0;
        rst = 1'b1;
        i = '0;
        s = '0;

        // Combinational table, clock stopped
        for (int k = 0; k < 9; k++) begin
            i = comb_i[k];
            #10;
            check("comb_F", 32'(F), 32'(comb_f[k]));
        end

        // Select sweep with both alternating patterns
        for (int p = 0; p < 2; p++) begin
            i = (p == 0) ? 4'b1010 : 4'b0101;
            for (int k = 0; k < 4; k++) begin
                s = 2'(k);
                #10;
                check("sweep_F", 32'(F), (p == 0) ? 32'(k & 1) : 32'((k & 1) ^ 1));
            end
        end

        // Reset held for two edges with all inputs high
        clk_en = 1'b1;
        rst = 1'b1; i = 4'b1111; s = 2'b11;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_F", 32'(F), 32'd1);
            check("rst_Fq", 32'(F_q), 32'd0);
            check("rst_cnt", 32'(tog_cnt), 32'd0);
        end
        rst = 1'b0;
        step();
        check("rel_Fq", 32'(F_q), 32'd1);
        check("rel_sel", 32'(sel_chg), 32'd1);
        check("rel_cnt", 32'(tog_cnt), 32'd1);

        // Select-change strobe: 01 held, one edge of 10, then held
        i = 4'b0000; s = 2'b01;
        for (int k = 0; k < 3; k++) step();
        check("strb_idle", 32'(sel_chg), 32'd0);
        s = 2'b10;
        step();
        check("strb_pulse", 32'(sel_chg), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("strb_hold", 32'(sel_chg), 32'd0);
        end

        // Saturation: toggle i[0] every edge, s=00, from reset
        rst = 1'b1; s = 2'b00; i = 4'b0000;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i[0] = ~i[0];
            step();
            check("sat_cnt", 32'(tog_cnt), 32'(sat_cnt[k]));
        end

        // Mid-operation reset at tog_cnt=2, then counting resumes from 0
        rst = 1'b1; i = 4'b0000;
        step();
        rst = 1'b0;
        i[0] = 1'b1; step();
        i[0] = 1'b0; step();
        check("mid_pre", 32'(tog_cnt), 32'd2);
        rst = 1'b1; i[0] = 1'b1; s = 2'b01; i[1] = 1'b1;
        step();
        check("mid_Fq", 32'(F_q), 32'd0);
        check("mid_sel", 32'(sel_chg), 32'd0);
        check("mid_cnt", 32'(tog_cnt), 32'd0);
        rst = 1'b0; s = 2'b00; i = 4'b0001;
        step();
        check("mid_resume", 32'(tog_cnt), 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            i   = 4'($urandom);
            s   = 2'($urandom);
            rst = ($urandom_range(0, 19) == 0);
            #1;
            check("rnd_F", 32'(F), 32'(ref_f(i, s)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_4x1.md
# mux_4x1

Single-bit 4-to-1 selector with a combinational data path and a small registered observation stage. `F` follows the selected input `i[s]` with zero latency. A clocked side stage provides a registered copy of `F`, a select-change strobe and a saturating toggle counter for downstream monitoring. The block sits in the adder/datapath test area as a reusable leaf selector.

## Interface
Parameters:
- `CNT_W`, default 8: width of the toggle counter `tog_cnt`, legal range 2–16.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock for all registered outputs.
- `rst`  in  1  synchronous, active-high reset of the registered stage.
- `i`  in  4  data inputs; `i[0]`..`i[3]` are candidates 0..3.
- `s`  in  2  select; `s[1]` is MSB.
- `F`  out  1  combinational selected data, `F = i[s]`.
- `F_q`  out  1  `F` registered on `clk`.
- `sel_chg`  out  1  one-cycle pulse when the sampled `s` differs from the previously sampled `s`.
- `tog_cnt`  out  `CNT_W`  saturating count of registered toggles of `F_q`.

## Operation
- Selection decode:
  - `s=00` gives `F=i[0]`.
  - `s=01` gives `F=i[1]`.
  - `s=10` gives `F=i[2]`.
  - `s=11` gives `F=i[3]`.
- Unselected inputs have no effect on `F`.
- `F` is purely combinational. It does not depend on `clk` or `rst`, and is valid with no clock running.
- X/Z on `s`: `F` is X in simulation. There is no defined recovery value.
- Registered stage:
  - internal register `s_q` (2 bits)
  - `F_q` (1 bit)
  - `sel_chg` (1 bit)
  - `tog_cnt` (`CNT_W` bits)
- On each rising `clk` with `rst=0`:
  - `F_q <= F`.
  - `s_q <= s`.
  - `sel_chg <= (s != s_q)`.
  - If `F != F_q` and `tog_cnt` is not all-ones, `tog_cnt <= tog_cnt + 1`. Otherwise `tog_cnt` holds.
- `tog_cnt` saturates at `2^CNT_W-1` and never wraps. It is cleared only by `rst`.
- A simultaneous select change and data change in one cycle is handled by each output independently. `sel_chg` and the `tog_cnt` increment may both occur on the same edge.

## Timing
- `F`: 0-cycle latency, combinational from `i` and `s`.
- `F_q`, `sel_chg`, `tog_cnt`: update on the rising `clk` edge and reflect inputs sampled at that edge (1-cycle latency).
- Reset (`rst=1` at a rising edge) forces `F_q=0`, `s_q=00`, `sel_chg=0`, `tog_cnt=0`. `F` is unaffected.
- Reset dominates all other updates on that edge.
- Reset asserted mid-operation clears on the next edge, with no partial state retained.
- First edge after reset release: `sel_chg=1` if `s!=00`. `tog_cnt` increments if `F=1`, because `F_q` reset to 0.
- `sel_chg` is high for exactly one cycle per change. A constant `s` yields `sel_chg=0` from the second edge onward.

## Test plan
- Combinational, `s=00`, no clock, 10 ns steps. `i` sequence and required `F`:
  - `i=0000` → `F=0`
  - `0001` → `1`
  - `1110` → `0`
  - `0010` → `0`
  - `1101` → `1`
  - `0100` → `0`
  - `1011` → `1`
  - `1000` → `0`
  - `0111` → `1`
- Select sweep, `i=1010`: `s=00` → `F=0`; `01` → `1`; `10` → `0`; `11` → `1`. Repeat with `i=0101` for the inverse pattern.
- Reset: drive `rst=1` for 2 edges with `i=1111`, `s=11`. Required: `F=1` throughout, `F_q=0`, `sel_chg=0`, `tog_cnt=0`. After release, first edge gives `F_q=1`, `sel_chg=1`, `tog_cnt=1`.
- Select-change strobe: hold `s=01`, then `s=10` for one edge, then hold. Required: `sel_chg` is 1 for exactly one cycle after the `01`→`10` edge, else 0.
- Counter saturation, `CNT_W=2`: toggle `i[0]` every cycle with `s=00` for 6 edges. Required `tog_cnt` sequence: 1, 2, 3, 3, 3, 3, with no wrap.
- Reset mid-operation: with `tog_cnt=2`, assert `rst` for 1 edge. Required: all registered outputs are 0 on that edge, and counting resumes from 0.
